// File: rtl/spi_ram_master.sv
// SPI master for the SPI RAM slave: one 10-bit command frame per handshake, 8-bit reply for read-data.
// Optional macro SPI_MASTER_SEQ_CHECK_EN adds the sticky rd_err read-sequencing check.
module spi_ram_master #(
  parameter int FRAME_W = 10,
  parameter int DATA_W  = 8,
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FRAME_W-1:0] cmd_word,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               rd_err,
  output logic               MOSI,
  input  logic               MISO,
  output logic               SS_n
);

  localparam int MAX_FD = (FRAME_W > DATA_W) ? FRAME_W : DATA_W;
  localparam int MAX_WG = (RD_WAIT > GAP) ? RD_WAIT : GAP;
  localparam int MAX_C  = (MAX_FD > MAX_WG) ? MAX_FD : MAX_WG;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_SHIFT, ST_WAIT, ST_RECV, ST_GAP
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_cmd_q, rd_cmd_d;
  logic               rd_valid_q, rd_valid_d;
  logic               ss_n_q, ss_n_d;
  logic               mosi_q, mosi_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               accept;
  logic [1:0]         cmd_code;
  logic [DATA_W-1:0]  rx_next;

  assign accept   = cmd_valid && cmd_ready_q;
  assign cmd_code = cmd_word[FRAME_W-1 -: 2];
  assign rx_next  = {rx_q[DATA_W-2:0], MISO};

  always_comb begin
    // NOTE: every *_d defaults to its hold value first, so no path through the case infers a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    rd_data_d   = rd_data_q;
    rd_cmd_d    = rd_cmd_q;
    rd_valid_d  = 1'b0;
    ss_n_d      = ss_n_q;
    mosi_d      = mosi_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d     = cmd_word;
          rd_cmd_d    = (cmd_code == 2'b11);
          cnt_d       = '0;
          ss_n_d      = 1'b0;
          mosi_d      = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        mosi_d  = shift_q[FRAME_W-1];
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (int'(cnt_q) == FRAME_W - 1) begin
          mosi_d = 1'b0;
          cnt_d  = '0;
          if (!rd_cmd_q) begin
            ss_n_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            state_d = (RD_WAIT == 0) ? ST_RECV : ST_WAIT;
          end
        end else begin
          mosi_d  = shift_q[FRAME_W-1];
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (int'(cnt_q) == RD_WAIT - 1) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RECV: begin
        rx_d = rx_next;
        if (int'(cnt_q) == DATA_W - 1) begin
          rd_data_d  = rx_next;
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (int'(cnt_q) == GAP - 1) begin
          cnt_d       = '0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples the pre-edge values.
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      rx_q        <= '0;
      rd_data_q   <= '0;
      rd_cmd_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      rd_data_q   <= rd_data_d;
      rd_cmd_q    <= rd_cmd_d;
      rd_valid_q  <= rd_valid_d;
      ss_n_q      <= ss_n_d;
      mosi_q      <= mosi_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
  assign MOSI      = mosi_q;
  assign SS_n      = ss_n_q;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic rd_err_q, rd_err_d;
  logic addr_seen_q, addr_seen_d;

  // A read-data command must be preceded by its own read-address command.
  always_comb begin
    rd_err_d    = rd_err_q;
    addr_seen_d = addr_seen_q;
    if (accept) begin
      if (cmd_code == 2'b10) begin
        addr_seen_d = 1'b1;
      end else if (cmd_code == 2'b11) begin
        if (!addr_seen_q) rd_err_d = 1'b1;
        addr_seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err_q    <= 1'b0;
      addr_seen_q <= 1'b0;
    end else begin
      rd_err_q    <= rd_err_d;
      addr_seen_q <= addr_seen_d;
    end
  end

  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

endmodule
